// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/ISSUE/DONE issue and writeback controller for the 4-bit ALU with a 4x4 register file.
// Optional macro ALU_ISSUE_STICKY_ERR_EN: an illegal opcode latches err and halts the controller until rst_n.
module alu_issue_ctrl #(
  parameter logic [3:0] REG_RST   = 4'h0,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic        done,
  output logic        err,
  output logic [3:0]  flags,
  input  logic [1:0]  dbg_sel,
  output logic [3:0]  dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] regs [4];
  logic [3:0] op, op_q, imm_q, iss_op, iss_a, iss_b;
  logic [1:0] rd, rs, rd_q;
  logic dec_alu, dec_cmp, dec_addi, q_alu, q_cmp, q_ldi, q_addi, q_ill, err_q, accept;
  function automatic logic is_alu(input logic [3:0] o);
    return o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA};
  endfunction
  assign op       = instr[11:8];
  assign rd       = instr[7:6];
  assign rs       = instr[5:4];
  assign dec_alu  = is_alu(op);
  assign dec_cmp  = op == 4'h5;
  assign dec_addi = op == 4'hB;
  // CMP reuses the ALU subtract; LDI and illegal opcodes leave the ALU idle
  assign iss_op   = dec_alu ? op : {3'b000, dec_cmp};
  assign iss_a    = (dec_alu || dec_cmp || dec_addi) ? regs[rd] : 4'h0;
  assign iss_b    = (dec_alu || dec_cmp) ? regs[rs] : dec_addi ? instr[3:0] : 4'h0;
  assign q_alu    = is_alu(op_q);
  assign q_cmp    = op_q == 4'h5;
  assign q_ldi    = op_q == 4'h6;
  assign q_addi   = op_q == 4'hB;
  assign q_ill    = !(q_alu || q_cmp || q_ldi || q_addi);
`ifdef ALU_ISSUE_STICKY_ERR_EN
  assign instr_ready = state == IDLE && !err_q;
`else
  assign instr_ready = state == IDLE;
`endif
  assign accept   = instr_valid && instr_ready;
  assign done     = state == DONE;
  assign err      = err_q;
  assign dbg_data = regs[dbg_sel];
  always_comb
    state_nxt = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? DONE : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= 4'h0;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
      op_q   <= 4'h0;
      imm_q  <= 4'h0;
      rd_q   <= 2'd0;
      err_q  <= 1'b0;
      flags  <= FLAGS_RST;
      for (int i = 0; i < 4; i++) regs[i] <= REG_RST;
    end else begin
      if (accept) begin
        alu_op <= iss_op;
        alu_a  <= iss_a;
        alu_b  <= iss_b;
        op_q   <= op;
        rd_q   <= rd;
        imm_q  <= instr[3:0];
      end else if (state == ISSUE) begin
        alu_op <= 4'h0;
        alu_a  <= 4'h0;
        alu_b  <= 4'h0;
      end
      if (state == ISSUE) begin
        if (q_alu || q_addi) regs[rd_q] <= alu_result;
        if (q_ldi) regs[rd_q] <= imm_q;
        if (q_alu || q_addi || q_cmp) flags <= alu_flags;
      end
`ifdef ALU_ISSUE_STICKY_ERR_EN
      err_q <= err_q || (state == ISSUE && q_ill);
`else
      err_q <= state == ISSUE && q_ill;
`endif
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table vectors, hand-written timing/reset sequences and random instructions checked against a reference model.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic [1:0]  dbg_sel = '0;
  logic        instr_ready, done, err;
  logic [3:0]  alu_op, alu_a, alu_b, alu_result, alu_flags, flags, dbg_data;
  int checks = 0, failures = 0;
  logic [3:0] mregs [4];
  logic [3:0] mflags;
  typedef struct {
    logic [11:0] ins;
    logic [1:0]  sel;
    logic [3:0]  val;
    logic [3:0]  fl;
  } vec_t;
  vec_t tbl [15];

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags), .done(done), .err(err),
    .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: returns {N,Z,V,C,result}; shifts use b[1:0], C = last bit shifted out
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    logic [3:0] r;
    logic v, c;
    t = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'h1: begin r = a - b; c = a < b; v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h8: begin t = {1'b0, a} << b[1:0]; r = t[3:0]; c = t[4]; v = r[3] ^ a[3]; end
      4'h9: begin t = {a, 1'b0} >> b[1:0]; r = t[4:1]; c = t[0]; end
      4'hA: begin t = $signed({a, 1'b0}) >>> b[1:0]; r = t[4:1]; c = t[0]; end
      default: ;
    endcase
    return {r[3], r == 4'h0, v, c, r};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural effect of one instruction, plus the ALU drive it should produce during ISSUE
  task automatic model(input logic [11:0] ins, output logic [3:0] eop, output logic [3:0] ea,
                       output logic [3:0] eb, output logic eerr);
    logic [3:0] o;
    logic [7:0] res;
    logic wr, wf;
    o = ins[11:8];
    eop = 4'h0; ea = 4'h0; eb = 4'h0; eerr = 1'b0; wr = 1'b0; wf = 1'b0;
    if (o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA}) begin
      eop = o; ea = mregs[ins[7:6]]; eb = mregs[ins[5:4]]; wr = 1'b1; wf = 1'b1;
    end else if (o == 4'h5) begin
      eop = 4'h1; ea = mregs[ins[7:6]]; eb = mregs[ins[5:4]]; wf = 1'b1;
    end else if (o == 4'hB) begin
      ea = mregs[ins[7:6]]; eb = ins[3:0]; wr = 1'b1; wf = 1'b1;
    end else if (o == 4'h6) mregs[ins[7:6]] = ins[3:0];
    else eerr = 1'b1;
    res = alu_f(eop, ea, eb);
    if (wr) mregs[ins[7:6]] = res[3:0];
    if (wf) mflags = res[7:4];
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mregs[i] = 4'h0;
    mflags = 4'h0;
  endtask

  task automatic run(input logic [11:0] ins);
    logic [3:0] eop, ea, eb;
    logic eerr;
    int n;
    model(ins, eop, ea, eb, eerr);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin chk("ready_timeout", 0, 1); return; end
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("issue_ready", instr_ready, 0);
    chk("issue_done", done, 0);
    chk("issue_alu_op", alu_op, eop);
    chk("issue_alu_a", alu_a, ea);
    chk("issue_alu_b", alu_b, eb);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_err", err, eerr);
    chk("done_flags", flags, mflags);
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      chk($sformatf("done_r%0d", s), dbg_data, mregs[s]);
    end
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_ready", instr_ready, 1);
    chk("idle_alu", {alu_op, alu_a, alu_b}, 12'h000);
  endtask

  initial begin
    int ntbl;
    logic [11:0] ins;
    logic [3:0] o;
    tbl[0]  = '{12'h647, 2'd1, 4'h7, 4'h0};
    tbl[1]  = '{12'h689, 2'd2, 4'h9, 4'h0};
    tbl[2]  = '{12'h060, 2'd1, 4'h0, 4'h5};
    tbl[3]  = '{12'h681, 2'd2, 4'h1, 4'h5};
    tbl[4]  = '{12'h647, 2'd1, 4'h7, 4'h5};
    tbl[5]  = '{12'h060, 2'd1, 4'h8, 4'hA};
    tbl[6]  = '{12'h603, 2'd0, 4'h3, 4'hA};
    tbl[7]  = '{12'h643, 2'd1, 4'h3, 4'hA};
    tbl[8]  = '{12'h510, 2'd0, 4'h3, 4'h4};
    tbl[9]  = '{12'h608, 2'd0, 4'h8, 4'h4};
    tbl[10] = '{12'h641, 2'd1, 4'h1, 4'h4};
    tbl[11] = '{12'hA10, 2'd0, 4'hC, 4'h8};
    tbl[12] = '{12'h608, 2'd0, 4'h8, 4'h8};
    tbl[13] = '{12'h810, 2'd0, 4'h0, 4'h7};
    tbl[14] = '{12'hF00, 2'd0, 4'h0, 4'h7};
`ifdef ALU_ISSUE_STICKY_ERR_EN
    ntbl = 14;
`else
    ntbl = 15;
`endif
    do_reset();
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 12'h000);
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      chk($sformatf("rst_r%0d", s), dbg_data, 0);
    end
    @(negedge clk);
    for (int i = 0; i < ntbl; i++) begin
      run(tbl[i].ins);
      dbg_sel = tbl[i].sel;
      #1;
      chk($sformatf("tbl%0d_reg", i), dbg_data, tbl[i].val);
      chk($sformatf("tbl%0d_flags", i), flags, tbl[i].fl);
      @(negedge clk);
    end
    // back-to-back ADDI r3,1 with instr_valid held high
    do_reset();
    dbg_sel = 2'd3;
    instr = 12'hBC1;
    instr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("b2b%0d_ready", k), instr_ready, k % 3 == 0);
      chk($sformatf("b2b%0d_done", k), done, k % 3 == 2);
      chk($sformatf("b2b%0d_alu_op", k), alu_op, 0);
      chk($sformatf("b2b%0d_alu_b", k), alu_b, k % 3 == 1);
      if (k % 3 == 2) chk($sformatf("b2b%0d_r3", k), dbg_data, k / 3 + 1);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    mregs[3] = 4'h3;
    mflags = 4'h0;
    // reset asserted while an ADD is in ISSUE
    do_reset();
    run(12'h645);
    instr = 12'h050;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("midrst_issue_a", alu_a, 5);
    rst_n = 1'b0;
    #1;
    dbg_sel = 2'd1;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_alu", {alu_op, alu_a, alu_b}, 12'h000);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_r1", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_r1", dbg_data, 0);
    chk("postrst_flags", flags, 0);
    chk("postrst_done", done, 0);
    // random instructions against the model
    do_reset();
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
`ifdef ALU_ISSUE_STICKY_ERR_EN
      if (o inside {4'h7, 4'hC, 4'hD, 4'hE, 4'hF}) o = 4'h6;
`endif
      ins = {o, 8'($urandom)};
      run(ins);
    end
`ifdef ALU_ISSUE_STICKY_ERR_EN
    do_reset();
    instr = 12'hC00;
    instr_valid = 1'b1;
    @(negedge clk);
    instr = 12'h060;
    @(negedge clk);
    chk("sticky_done", done, 1);
    chk("sticky_err", err, 1);
    repeat (5) begin
      @(negedge clk);
      chk("sticky_hold_err", err, 1);
      chk("sticky_hold_ready", instr_ready, 0);
      chk("sticky_hold_done", done, 0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("sticky_rst_err", err, 0);
    chk("sticky_rst_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
